// File: rtl/ram_ctrl_pkg.sv
// Shared types for the note/map RAM bank pair: bank ids, reader states, default widths.
// Used by both the write-side bank controller and the read-side scanner.
package ram_ctrl_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    localparam logic BANK_RAM1 = 1'b0;
    localparam logic BANK_RAM2 = 1'b1;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_READ  = 2'd1,
        RD_DRAIN = 2'd2,
        RD_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry skid buffer; rdata is the head and is valid whenever count != 0.
// Zero-latency read, one-cycle write; the caller must never push when full.
module rd_skid_fifo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/double_buffer_reader.sv
// Scans the read-side note RAM bank once per start and streams entries in address order.
// First word 3 cycles after start; 1 word/cycle under out_ready; at most 2 words buffered or in flight.
module double_buffer_reader
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = 160
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              bank_sel,
    output logic              ram1_rd_en,
    output logic              ram2_rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram1_rd_data,
    input  logic [DATA_W-1:0] ram2_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              frame_done,
    output logic              swap_req
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    rd_state_t                  state;
    logic                       bank;
    logic [ADDR_W-1:0]          addr;
    logic                       inflight;
    logic [ADDR_W-1:0]          inflight_addr;
    logic [1:0]                 fifo_count;
    logic                       fifo_pop;
    logic                       issue;
    logic [2:0]                 credit_used;
    logic [DATA_W-1:0]          rd_data_mux;
    logic [DATA_W+ADDR_W-1:0]   fifo_wdata;
    logic [DATA_W+ADDR_W-1:0]   fifo_rdata;

    assign out_valid = (fifo_count != 2'd0);
    assign fifo_pop  = out_valid & out_ready;

    // The slot freed by this cycle's pop is counted as available so a steady stream has no bubbles.
    assign credit_used = {1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight};
    assign issue       = (state == RD_READ) && (credit_used < 3'd2);

    assign ram1_rd_en = issue && (bank == BANK_RAM1);
    assign ram2_rd_en = issue && (bank == BANK_RAM2);
    assign rd_addr    = addr;

    assign rd_data_mux = (bank == BANK_RAM2) ? ram2_rd_data : ram1_rd_data;
    assign fifo_wdata  = {rd_data_mux, inflight_addr};

    assign out_data   = fifo_rdata[ADDR_W +: DATA_W];
    assign out_index  = fifo_rdata[ADDR_W-1:0];
    assign busy       = (state != RD_IDLE);
    assign frame_done = (state == RD_DONE);
    assign swap_req   = (state == RD_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= RD_IDLE;
            bank          <= BANK_RAM1;
            addr          <= '0;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr <= addr;
            end
            case (state)
                RD_IDLE: begin
                    if (start) begin
                        bank  <= bank_sel;
                        addr  <= '0;
                        state <= RD_READ;
                    end
                end
                RD_READ: begin
                    if (issue) begin
                        if (addr == LAST_ADDR) begin
                            state <= RD_DRAIN;
                        end else begin
                            addr <= addr + ADDR_W'(1);
                        end
                    end
                end
                RD_DRAIN: begin
                    // Leave once the final word has been handed over (or already was).
                    if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && fifo_pop))) begin
                        state <= RD_DONE;
                    end
                end
                RD_DONE: begin
                    addr  <= '0;
                    state <= RD_IDLE;
                end
                default: state <= RD_IDLE;
            endcase
        end
    end

    rd_skid_fifo #(
        .W (DATA_W + ADDR_W)
    ) u_skid (
        .clk    (clk),
        .resetn (resetn),
        .push   (inflight),
        .wdata  (fifo_wdata),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .count  (fifo_count)
    );

endmodule
